// File: rtl/adc_dout_emulator.sv
`timescale 1ns / 1ps
// Serialises eight 24-bit samples per frame onto DRDY/DCLK/DOUT0..3. Frame starts are FRAME_PERIOD cycles apart.
// The ch*_i inputs are latched on the frame-start cycle. There is no backpressure: the frame clock free-runs.
module adc_dout_emulator #(
  parameter int CLK_DIV      = 2,
  parameter int FRAME_PERIOD = 976
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [23:0] ch1_i,
  input  logic [23:0] ch2_i,
  input  logic [23:0] ch3_i,
  input  logic [23:0] ch4_i,
  input  logic [23:0] ch5_i,
  input  logic [23:0] ch6_i,
  input  logic [23:0] ch7_i,
  input  logic [23:0] ch8_i,
  output logic        drdy_o,
  output logic        dclk_o,
  output logic [3:0]  dout_o,
  output logic        frame_start_o,
  output logic        busy_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = $clog2(FRAME_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(FRAME_PERIOD - 1);

  if (CLK_DIV < 1 || FRAME_PERIOD < 128 * CLK_DIV + 2) begin : g_param_check
    $error("adc_dout_emulator: need CLK_DIV >= 1 and FRAME_PERIOD >= 128*CLK_DIV + 2");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e           state_q, state_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic             dclk_q, dclk_d;
  logic             start_q, start_d;
  logic [63:0]      line_q [4];
  logic [63:0]      line_d [4];
  logic [23:0]      ch [8];

  assign ch[0] = ch1_i;
  assign ch[1] = ch2_i;
  assign ch[2] = ch3_i;
  assign ch[3] = ch4_i;
  assign ch[4] = ch5_i;
  assign ch[5] = ch6_i;
  assign ch[6] = ch7_i;
  assign ch[7] = ch8_i;

  function automatic logic [31:0] slot(input logic [2:0] chid, input logic [23:0] sample);
    return {5'b00000, chid, sample};
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      per_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      dclk_q  <= 1'b0;
      start_q <= 1'b0;
      for (int k = 0; k < 4; k++) line_q[k] <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      dclk_q  <= dclk_d;
      start_q <= start_d;
      for (int k = 0; k < 4; k++) line_q[k] <= line_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    div_d   = div_q;
    bit_d   = bit_q;
    dclk_d  = dclk_q;
    start_d = 1'b0;
    for (int k = 0; k < 4; k++) line_d[k] = line_q[k];
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = SHIFT;
          start_d = 1'b1;
          per_d   = '0;
          div_d   = '0;
          bit_d   = '0;
          dclk_d  = 1'b0;
        end
      end
      SHIFT: begin
        per_d = per_q + 1'b1;
        // Shadow load happens at the end of the frame-start cycle; bit 31 of every slot is 0 until then.
        if (start_q) begin
          for (int k = 0; k < 4; k++)
            line_d[k] = {slot(3'(2 * k), ch[2 * k]), slot(3'(2 * k + 1), ch[2 * k + 1])};
        end
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          dclk_d = ~dclk_q;
          if (dclk_q) begin
            bit_d = bit_q + 1'b1;
            for (int k = 0; k < 4; k++) line_d[k] = {line_q[k][62:0], 1'b0};
            if (bit_q == 6'd63) state_d = GAP;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (per_q == PER_LAST) begin
          per_d = '0;
          if (enable_i) begin
            state_d = SHIFT;
            start_d = 1'b1;
            div_d   = '0;
            bit_d   = '0;
            dclk_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q == SHIFT);
    frame_start_o = start_q;
    drdy_o        = (state_q == SHIFT) && (bit_q == 6'd0);
    dclk_o        = (state_q == SHIFT) && dclk_q;
    dout_o        = '0;
    if (state_q == SHIFT && !start_q) begin
      for (int k = 0; k < 4; k++) dout_o[k] = line_q[k][63];
    end
  end

endmodule
